// File: rtl/game_fsm.sv
// Game-flow controller: IDLE/PLAYING/FINISH sequencing, distance countdown and
// LFSR-driven spawning/retiring of one coin and one barrier lane for the compositor.
module game_fsm #(
  parameter logic [11:0] START_DISTANCE   = 12'd999,
  parameter int          FRAMES_PER_METER = 4,
  parameter int          SPAWN_PERIOD     = 64,
  parameter int          OBJECT_FRAMES    = 48
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_frame_tick,
  input  logic        i_coin_hit,
  input  logic        i_barrier_hit,
  input  logic        i_zero_lives,
  output logic [7:0]  o_current_state,
  output logic [11:0] o_remaining_distance,
  output logic [1:0]  o_active_coin,
  output logic [1:0]  o_active_barrier,
  output logic        o_win
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  localparam logic [15:0] FPM_LAST = 16'(FRAMES_PER_METER - 1);
  localparam logic [15:0] SP_LAST  = 16'(SPAWN_PERIOD - 1);
  localparam logic [15:0] SP_HALF  = 16'(SPAWN_PERIOD / 2);
  localparam logic [15:0] OBJ_LAST = 16'(OBJECT_FRAMES - 1);

  state_t      state_q, state_d;
  logic [3:0]  in_q, prev_q, ev_q, ev_d;   // {barrier_hit, coin_hit, frame, start}
  logic        zl_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [11:0] dist_q, dist_d;
  logic [15:0] meter_q, meter_d, spawn_q, spawn_d;
  logic [15:0] coin_life_q, coin_life_d, bar_life_q, bar_life_d;
  logic [1:0]  coin_q, coin_d, bar_q, bar_d;
  logic        win_q, win_d;

  logic        start_ev, frame_ev, coin_ev, bar_ev;
  logic [1:0]  bar_lane, coin_lane;
  logic        bar_clear, coin_clear;

  assign start_ev = ev_q[0];
  assign frame_ev = ev_q[1];
  assign coin_ev  = ev_q[2];
  assign bar_ev   = ev_q[3];
  assign ev_d     = in_q & ~prev_q;
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      in_q        <= '0;
      prev_q      <= '0;
      ev_q        <= '0;
      zl_q        <= 1'b0;
      lfsr_q      <= 16'hACE1;
      dist_q      <= START_DISTANCE;
      meter_q     <= '0;
      spawn_q     <= '0;
      coin_life_q <= '0;
      bar_life_q  <= '0;
      coin_q      <= 2'b00;
      bar_q       <= 2'b00;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= {i_barrier_hit, i_coin_hit, i_frame_tick, i_start};
      prev_q      <= in_q;
      ev_q        <= ev_d;
      zl_q        <= i_zero_lives;
      lfsr_q      <= lfsr_d;
      dist_q      <= dist_d;
      meter_q     <= meter_d;
      spawn_q     <= spawn_d;
      coin_life_q <= coin_life_d;
      bar_life_q  <= bar_life_d;
      coin_q      <= coin_d;
      bar_q       <= bar_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ev) state_d = S_PLAYING;
      S_PLAYING: if (zl_q || dist_q == 12'd0) state_d = S_FINISH;
      S_FINISH:  if (start_ev) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Coin lane is nudged off the barrier lane so the two never overlap.
  always_comb begin
    bar_lane  = (lfsr_q[1:0] == 2'b00) ? 2'b10 : lfsr_q[1:0];
    coin_lane = bar_lane;
    if (bar_q != 2'b00 && bar_lane == bar_q) begin
      case (bar_lane)
        2'b01:   coin_lane = 2'b10;
        2'b10:   coin_lane = 2'b11;
        default: coin_lane = 2'b01;
      endcase
    end
  end

  always_comb begin
    dist_d      = dist_q;
    meter_d     = meter_q;
    spawn_d     = spawn_q;
    coin_life_d = coin_life_q;
    bar_life_d  = bar_life_q;
    coin_d      = coin_q;
    bar_d       = bar_q;
    win_d       = win_q;
    bar_clear   = bar_ev  || (frame_ev && bar_q  != 2'b00 && bar_life_q  == OBJ_LAST);
    coin_clear  = coin_ev || (frame_ev && coin_q != 2'b00 && coin_life_q == OBJ_LAST);
    case (state_q)
      S_IDLE: begin
        win_d = 1'b0;
        if (state_d == S_PLAYING) begin
          dist_d      = START_DISTANCE;
          meter_d     = '0;
          spawn_d     = '0;
          coin_life_d = '0;
          bar_life_d  = '0;
          coin_d      = 2'b00;
          bar_d       = 2'b00;
        end
      end
      S_PLAYING: begin
        if (state_d == S_FINISH) begin
          coin_d = 2'b00;
          bar_d  = 2'b00;
          win_d  = ~zl_q;
        end else begin
          if (frame_ev) begin
            if (meter_q == FPM_LAST) begin
              meter_d = '0;
              if (dist_q != 12'd0) dist_d = dist_q - 12'd1;
            end else begin
              meter_d = meter_q + 16'd1;
            end
            spawn_d = (spawn_q == SP_LAST) ? 16'd0 : spawn_q + 16'd1;
            if (bar_q  != 2'b00) bar_life_d  = bar_life_q + 16'd1;
            if (coin_q != 2'b00) coin_life_d = coin_life_q + 16'd1;
          end
          // A clear in the same cycle suppresses the spawn; nothing is deferred.
          if (bar_clear) begin
            bar_d = 2'b00;
          end else if (frame_ev && spawn_q == 16'd0 && bar_q == 2'b00) begin
            bar_d      = bar_lane;
            bar_life_d = '0;
          end
          if (coin_clear) begin
            coin_d = 2'b00;
          end else if (frame_ev && spawn_q == SP_HALF && coin_q == 2'b00) begin
            coin_d      = coin_lane;
            coin_life_d = '0;
          end
        end
      end
      S_FINISH: begin
        coin_d = 2'b00;
        bar_d  = 2'b00;
        if (state_d == S_IDLE) win_d = 1'b0;
      end
      default: begin
        coin_d = 2'b00;
        bar_d  = 2'b00;
        win_d  = 1'b0;
      end
    endcase
  end

  assign o_current_state      = {6'b000000, state_q};
  assign o_remaining_distance = dist_q;
  assign o_active_coin        = coin_q;
  assign o_active_barrier     = bar_q;
  assign o_win                = win_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: start/finish flow, distance countdown, spawn,
// hit, retire and reset behaviour, with a short-distance second instance.
module tb_game_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, frame_tick, coin_hit, barrier_hit, zero_lives;
  logic [7:0]  state_a, state_b;
  logic [11:0] dist_a, dist_b;
  logic [1:0]  coin_a, coin_b, bar_a, bar_b;
  logic        win_a, win_b;
  logic [1:0]  bar_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_fsm dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_tick(frame_tick),
    .i_coin_hit(coin_hit), .i_barrier_hit(barrier_hit), .i_zero_lives(zero_lives),
    .o_current_state(state_a), .o_remaining_distance(dist_a),
    .o_active_coin(coin_a), .o_active_barrier(bar_a), .o_win(win_a)
  );

  game_fsm #(.START_DISTANCE(12'd2)) dut_short (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_tick(frame_tick),
    .i_coin_hit(coin_hit), .i_barrier_hit(barrier_hit), .i_zero_lives(zero_lives),
    .o_current_state(state_b), .o_remaining_distance(dist_b),
    .o_active_coin(coin_b), .o_active_barrier(bar_b), .o_win(win_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed condition %b expected 1", tag, cond);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick(1);
      frame_tick = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0;
    coin_hit = 1'b0; barrier_hit = 1'b0; zero_lives = 1'b0;
    tick(3);
    check("reset_state", 16'(state_a), 16'h00);
    check("reset_dist", 16'(dist_a), 16'd999);
    check("reset_coin", 16'(coin_a), 16'h0);
    check("reset_barrier", 16'(bar_a), 16'h0);
    check("reset_win", 16'(win_a), 16'h0);
    check("reset_dist_short", 16'(dist_b), 16'd2);
    rst_n = 1'b1;
    tick(2);

    // Start: event registers one edge later, state moves on the second.
    start = 1'b1;
    tick(2);
    check("start_not_yet", 16'(state_a), 16'h00);
    tick(1);
    check("start_playing", 16'(state_a), 16'h01);
    check("start_dist", 16'(dist_a), 16'd999);
    check("start_coin", 16'(coin_a), 16'h0);
    check("start_barrier", 16'(bar_a), 16'h0);
    start = 1'b0;

    // 8 frames: distance 997; short instance reaches 0 and wins.
    frames(8);
    tick(2);
    check("dist_8_frames", 16'(dist_a), 16'd997);
    check_true("barrier_spawned", bar_a != 2'b00);
    bar_seen = bar_a;
    check("short_state", 16'(state_b), 16'h02);
    check("short_dist", 16'(dist_b), 16'd0);
    check("short_win", 16'(win_b), 16'h1);
    check("short_actives", 16'({coin_b, bar_b}), 16'h0);

    // Coin spawns on the 33rd frame (count 32), off the barrier lane.
    frames(24);
    tick(2);
    check("coin_before_half", 16'(coin_a), 16'h0);
    frames(1);
    tick(2);
    check_true("coin_spawned", coin_a != 2'b00);
    check_true("coin_lane_differs", coin_a != bar_a);
    check("barrier_still", 16'(bar_a), 16'(bar_seen));
    check("dist_33_frames", 16'(dist_a), 16'd991);

    // Coin hit held 5 cycles: cleared two edges after the rise.
    coin_hit = 1'b1;
    tick(2);
    check_true("coin_hit_not_yet", coin_a != 2'b00);
    tick(1);
    check("coin_hit_clear", 16'(coin_a), 16'h0);
    tick(2);
    coin_hit = 1'b0;
    tick(2);
    check("coin_stays_clear", 16'(coin_a), 16'h0);

    // Barrier spawned on frame 1 retires on frame 49.
    frames(15);
    tick(2);
    check("barrier_before_retire", 16'(bar_a), 16'(bar_seen));
    frames(1);
    tick(2);
    check("barrier_retired", 16'(bar_a), 16'h0);

    // Barrier hit on the frame-65 spawn cycle suppresses that spawn.
    frames(15);
    frame_tick = 1'b1; barrier_hit = 1'b1;
    tick(1);
    frame_tick = 1'b0; barrier_hit = 1'b0;
    tick(1);
    tick(2);
    check("barrier_spawn_blocked", 16'(bar_a), 16'h0);
    frames(63);
    tick(2);
    check("barrier_no_deferred", 16'(bar_a), 16'h0);
    frames(1);
    tick(2);
    check_true("barrier_next_period", bar_a != 2'b00);
    check_true("coin_second_period", coin_a != 2'b00);
    check("dist_129_frames", 16'(dist_a), 16'd967);

    // Run down to 500, then zero lives ends the game without a win.
    frames(1996 - 129);
    tick(2);
    check("dist_500", 16'(dist_a), 16'd500);
    zero_lives = 1'b1;
    tick(1);
    check("zl_not_yet", 16'(state_a), 16'h01);
    tick(1);
    check("zl_finish", 16'(state_a), 16'h02);
    check("zl_win", 16'(win_a), 16'h0);
    check("zl_dist_hold", 16'(dist_a), 16'd500);
    check("zl_actives", 16'({coin_a, bar_a}), 16'h0);
    frames(8);
    tick(2);
    check("finish_dist_hold", 16'(dist_a), 16'd500);
    check("finish_actives", 16'({coin_a, bar_a}), 16'h0);
    zero_lives = 1'b0;

    // Start from FINISH returns to IDLE, next start replays.
    start = 1'b1;
    tick(3);
    start = 1'b0;
    check("finish_to_idle", 16'(state_a), 16'h00);
    check("idle_win", 16'(win_a), 16'h0);
    tick(2);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    check("replay_playing", 16'(state_a), 16'h01);
    check("replay_dist", 16'(dist_a), 16'd999);
    frames(6);
    tick(2);
    check("replay_dist_6", 16'(dist_a), 16'd998);
    check_true("replay_barrier", bar_a != 2'b00);

    // Asynchronous reset mid-game.
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", 16'(state_a), 16'h00);
    check("areset_dist", 16'(dist_a), 16'd999);
    check("areset_actives", 16'({coin_a, bar_a}), 16'h0);
    check("areset_win", 16'(win_a), 16'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_reset_idle", 16'(state_a), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
# game_fsm

Game-flow controller directly upstream of the graphics compositor top. Runs the IDLE/PLAYING/FINISH state machine, counts down the remaining distance, and spawns and retires one coin and one barrier lane with an LFSR. Consumes the compositor's coin-hit, barrier-hit and zero-lives feedback. Drives the state, distance and active-object buses that the compositor renders.

## Interface
- START_DISTANCE, 12'd999: distance loaded on entry to PLAYING; must be ≤ 999 so the three-digit display stays valid.
- FRAMES_PER_METER, 4: frame events per one-unit distance decrement; ≥ 1.
- SPAWN_PERIOD, 64: frame events per spawn cycle; even, ≥ 4.
- OBJECT_FRAMES, 48: frame events an object stays active before it retires unhit; < SPAWN_PERIOD.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  start/restart button level, already debounced.
- i_frame_tick  in  1  sprite refresher level; a rising edge marks one frame.
- i_coin_hit  in  1  compositor coin-hit level.
- i_barrier_hit  in  1  compositor barrier-hit level.
- i_zero_lives  in  1  compositor out-of-lives level.
- o_current_state  out  8  8'h00 IDLE, 8'h01 PLAYING, 8'h02 FINISH.
- o_remaining_distance  out  12  remaining distance, 0..START_DISTANCE.
- o_active_coin  out  2  00 none, 01 left, 10 mid, 11 right.
- o_active_barrier  out  2  same encoding as o_active_coin.
- o_win  out  1  high in FINISH when distance reached 0; low otherwise.

## Operation
- Edge detect: i_start, i_frame_tick, i_coin_hit and i_barrier_hit each go through one register. An event is (cur & ~prev).
- "Frame event" means the i_frame_tick rising-edge pulse, one cycle wide.
- IDLE → PLAYING on a start event. On entry:
  - distance ← START_DISTANCE
  - meter divider, spawn timer and both lifetime counters ← 0
  - both actives ← 00
- PLAYING → FINISH when distance == 0 or i_zero_lives == 1, evaluated every cycle. Zero lives takes precedence, so o_win = 0 if both hold.
- FINISH → IDLE on a start event. FINISH holds distance; actives are forced to 00.
- Start events in PLAYING are ignored.
- Distance: the meter divider counts frame events 0..FRAMES_PER_METER-1. On wrap, distance decrements by 1 and saturates at 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle in all states.
- Lane: r = lfsr[1:0]; lane = (r == 00) ? 10 : r.
- Spawn timer counts frame events 0..SPAWN_PERIOD-1 in PLAYING.
  - Barrier spawns at count 0, only if o_active_barrier == 00.
  - Coin spawns at count SPAWN_PERIOD/2, only if o_active_coin == 00.
  - If the chosen coin lane equals the current non-zero barrier lane, it rotates 01→10→11→01.
- Each active slot has a lifetime counter reset at spawn and incremented per frame event. At OBJECT_FRAMES the slot retires to 00.
- A coin-hit event clears the coin slot; a barrier-hit event clears the barrier slot. Hit events outside PLAYING are ignored.
- Simultaneous events on the same slot, same cycle: clear (hit or retire) wins over spawn. The skipped spawn waits for the next period; no deferred spawn is queued.

## Timing
- Reset values:
  - o_current_state = 8'h00
  - o_remaining_distance = START_DISTANCE
  - o_active_coin = 00, o_active_barrier = 00
  - o_win = 0
  - edge-detect registers = 0
- All outputs are registered.
- Input edge to action: the input is sampled at edge N, the event registers at N+1, the output updates at N+2. This applies to start, frame events and hits.
- A FINISH condition true at edge N gives o_current_state = 8'h02 after edge N+1. Actives read 00 in that same cycle.
- Reset asserted mid-game returns everything to reset values immediately (asynchronous). The LFSR reseeds.
- i_zero_lives is level-sampled; no edge detect.

## Test plan
- Reset, then start pulse → state 00 → 01 two cycles after the edge; distance 999; actives 00.
- FRAMES_PER_METER = 4, 8 frame edges → distance 997. Override START_DISTANCE = 2, 8 frames → distance 0, state 02, o_win = 1.
- PLAYING, first frame event → barrier goes non-zero on count 0. Coin spawns 32 frames later in a lane different from the barrier.
- Coin active, i_coin_hit held high 5 cycles → coin 00 two cycles after the rising edge; exactly one clear. A barrier spawned unhit retires to 00 after 48 frames.
- Barrier hit coinciding with a barrier spawn cycle → barrier stays 00 until the next spawn period.
- i_zero_lives = 1 with distance 500 → state 02, o_win = 0, distance holds 500. A start pulse then → IDLE. Async reset mid-PLAYING → all reset values.
